// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
// Optional build macro used by uart_rx: UART_RX_MAJORITY_EN.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      RECOVER
   } state_t;

   // Oversample ratio is a fixed property of the receiver, not a parameter.
   localparam int OVS = 16;

   // Positions within one bit period, counted in oversample ticks.
   localparam logic [3:0] SAMPLE_POS = 4'd7;
   localparam logic [3:0] DECIDE_POS = 4'd8;
   localparam logic [3:0] LAST_POS   = 4'd15;

   localparam int ACC_W = 32;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: fractional phase-accumulator tick generator.
// Emits one-cycle tick_o at an average rate of MULT*BAUD per second.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int CLK_HZ = 100000000,
   parameter int BAUD   = 115200,
   parameter int MULT   = OVS
) (
   input  logic sys_clk_i,
   input  logic sys_rstn_i,
   output logic tick_o
);

   // One extra bit so acc+INC can never wrap before the compare.
   localparam logic [ACC_W:0] INC   = (ACC_W+1)'(MULT * BAUD);
   localparam logic [ACC_W:0] CLK_L = (ACC_W+1)'(CLK_HZ);

   logic [ACC_W-1:0] r_acc;
   logic [ACC_W:0]   w_sum;
   logic [ACC_W:0]   w_next;

   assign w_sum  = {1'b0, r_acc} + INC;
   assign tick_o = (w_sum >= CLK_L);
   assign w_next = tick_o ? (w_sum - CLK_L) : w_sum;

   // Free-running accumulator; nothing outside this module ever resets it.
   always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
      if (!sys_rstn_i) r_acc <= '0;
      else             r_acc <= w_next[ACC_W-1:0];
   end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver, 16x oversampled, valid/ack byte handshake.
// Build macro UART_RX_MAJORITY_EN: 2-of-3 vote over os_cnt 6/7/8 instead
// of a single sample at os_cnt 7.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_HZ = 100000000,
   parameter int BAUD   = 115200
) (
   input  logic       sys_clk_i,
   input  logic       sys_rstn_i,
   input  logic       uart_rx_i,
   input  logic       uart_ack_i,
   output logic [7:0] uart_dat_o,
   output logic       uart_valid_o,
   output logic       uart_ferr_o,
   output logic       uart_ovr_o,
   output logic       uart_busy_o
);

   logic       r_sync1, r_sync2;
   logic       w_rx_s;
   logic       w_tick;
   state_t     r_state, w_next;
   logic [3:0] r_os_cnt;
   logic [2:0] r_bit_idx;
   logic [7:0] r_shift;
   logic       r_bit;
   logic       r_s7;
   logic       w_sample;
   logic       w_at_decide, w_at_last;
   logic       w_os_clr, w_bit_clr, w_cap, w_shift, w_deliver, w_ferr;

   uart_baud_tick #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .MULT(OVS)) u_tick (
      .sys_clk_i  (sys_clk_i),
      .sys_rstn_i (sys_rstn_i),
      .tick_o     (w_tick)
   );

   // Two-flop synchronizer; the line idles high so both stages reset to 1.
   always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
      if (!sys_rstn_i) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= uart_rx_i;
         r_sync2 <= r_sync1;
      end
   end
   assign w_rx_s = r_sync2;

   // Capture the centre sample ahead of the decision tick.
   always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
      if (!sys_rstn_i)                             r_s7 <= 1'b1;
      else if (w_tick && r_os_cnt == SAMPLE_POS)   r_s7 <= w_rx_s;
   end

`ifdef UART_RX_MAJORITY_EN
   logic r_s6;
   // Extra early sample for the vote; the third vote is live rx_s at the decision tick.
   always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
      if (!sys_rstn_i)                                  r_s6 <= 1'b1;
      else if (w_tick && r_os_cnt == SAMPLE_POS - 4'd1) r_s6 <= w_rx_s;
   end
   assign w_sample = (r_s6 & r_s7) | (r_s6 & w_rx_s) | (r_s7 & w_rx_s);
`else
   assign w_sample = r_s7;
`endif

   assign w_at_decide = w_tick && (r_os_cnt == DECIDE_POS);
   assign w_at_last   = w_tick && (r_os_cnt == LAST_POS);

   // State register.
   always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
      if (!sys_rstn_i) r_state <= IDLE;
      else             r_state <= w_next;
   end

   // Next-state and datapath strobes.
   always_comb begin
      w_next    = r_state;
      w_os_clr  = 1'b0;
      w_bit_clr = 1'b0;
      w_cap     = 1'b0;
      w_shift   = 1'b0;
      w_deliver = 1'b0;
      w_ferr    = 1'b0;
      case (r_state)
         IDLE: if (!w_rx_s) begin
            w_next   = START;
            w_os_clr = 1'b1;
         end
         START: begin
            if (w_at_decide && w_sample) w_next = IDLE;   // glitch, not a start bit
            else if (w_at_last) begin
               w_next    = DATA;
               w_bit_clr = 1'b1;
            end
         end
         DATA: begin
            if (w_at_decide) w_cap = 1'b1;
            else if (w_at_last) begin
               w_shift = 1'b1;
               if (r_bit_idx == 3'd7) w_next = STOP;
            end
         end
         // Decide at stop-bit centre so a following start bit is not missed.
         STOP: if (w_at_decide) begin
            if (w_sample) begin
               w_deliver = 1'b1;
               w_next    = IDLE;
            end else begin
               w_ferr = 1'b1;
               w_next = RECOVER;
            end
         end
         // Wait out a break so a held-low line does not look like new starts.
         RECOVER: if (w_rx_s) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Oversample counter, bit index and LSB-first shifter.
   always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
      if (!sys_rstn_i) begin
         r_os_cnt  <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_bit     <= 1'b0;
      end else begin
         if (w_os_clr)    r_os_cnt <= '0;
         else if (w_tick) r_os_cnt <= r_os_cnt + 4'd1;
         if (w_bit_clr)    r_bit_idx <= '0;
         else if (w_shift) r_bit_idx <= r_bit_idx + 3'd1;
         if (w_cap)   r_bit   <= w_sample;
         if (w_shift) r_shift <= {r_bit, r_shift[7:1]};
      end
   end

   // Output byte handshake: delivery beats ack, overrun when nobody took the old byte.
   always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
      if (!sys_rstn_i) begin
         uart_dat_o   <= '0;
         uart_valid_o <= 1'b0;
         uart_ferr_o  <= 1'b0;
         uart_ovr_o   <= 1'b0;
      end else begin
         uart_ferr_o <= w_ferr;
         if (w_deliver) begin
            uart_dat_o   <= r_shift;
            uart_valid_o <= 1'b1;
            uart_ovr_o   <= uart_valid_o & ~uart_ack_i;
         end else if (uart_ack_i && uart_valid_o) begin
            uart_valid_o <= 1'b0;
            uart_ovr_o   <= 1'b0;
         end
      end
   end

   assign uart_busy_o = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven frames plus hand-written corner sequences,
// expected bytes tracked through a scoreboard queue.
module tb_uart_rx;

   localparam int    CLK_HZ = 10000000;   // 100-unit clock period
   localparam int    BAUD   = 115200;
   localparam real   BIT0   = 1.0e9 / 115200.0;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx = 1'b1;
   logic       ack = 1'b0;
   logic [7:0] dat;
   logic       valid, ferr, ovr, busy;

   int n_pass = 0;
   int n_chk  = 0;
   int ferr_cnt = 0;
   logic [7:0] exp_q[$];

   typedef struct packed {
      logic [7:0] data;
      int         skew_pct;
      logic [7:0] exp_dat;
   } vec_t;
   vec_t tbl[5];

   uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
      .sys_clk_i    (clk),
      .sys_rstn_i   (rst_n),
      .uart_rx_i    (rx),
      .uart_ack_i   (ack),
      .uart_dat_o   (dat),
      .uart_valid_o (valid),
      .uart_ferr_o  (ferr),
      .uart_ovr_o   (ovr),
      .uart_busy_o  (busy)
   );

   always #50 clk = ~clk;

   always @(negedge clk) if (ferr === 1'b1) ferr_cnt++;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", nm, act, exp);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input real bns);
      rx = 1'b0;
      #(bns);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         #(bns);
      end
      rx = stop;
      #(bns);
      if (stop) rx = 1'b1;
   endtask

   task automatic ack_pulse();
      @(negedge clk) ack = 1'b1;
      @(negedge clk) ack = 1'b0;
   endtask

   task automatic wait_valid(input string nm);
      int k = 0;
      @(negedge clk);
      while (valid !== 1'b1 && k < 2000) begin
         @(negedge clk);
         k++;
      end
      check({nm, "_valid"}, {31'd0, valid}, 32'd1);
   endtask

   // Pop expected bytes up to and including the last one queued; dat must match it.
   task automatic pop_cmp(input string nm);
      logic [7:0] e;
      if (exp_q.size() == 0) begin
         check({nm, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         while (exp_q.size() > 0) e = exp_q.pop_front();
         check({nm, "_dat"}, {24'd0, dat}, {24'd0, e});
      end
   endtask

   task automatic get_byte(input string nm);
      wait_valid(nm);
      pop_cmp(nm);
      check({nm, "_ovr"}, {31'd0, ovr}, 32'd0);
      ack_pulse();
      check({nm, "_ack_clr"}, {31'd0, valid}, 32'd0);
   endtask

   initial begin
      real bns;
      tbl[0] = '{data: 8'h55, skew_pct:  0, exp_dat: 8'h55};
      tbl[1] = '{data: 8'h00, skew_pct:  0, exp_dat: 8'h00};
      tbl[2] = '{data: 8'hFF, skew_pct:  0, exp_dat: 8'hFF};
      tbl[3] = '{data: 8'hF0, skew_pct:  3, exp_dat: 8'hF0};
      tbl[4] = '{data: 8'hF0, skew_pct: -3, exp_dat: 8'hF0};

      // reset state
      #130;
      check("rst_dat",   {24'd0, dat},   32'd0);
      check("rst_valid", {31'd0, valid}, 32'd0);
      check("rst_ferr",  {31'd0, ferr},  32'd0);
      check("rst_ovr",   {31'd0, ovr},   32'd0);
      check("rst_busy",  {31'd0, busy},  32'd0);
      @(negedge clk) rst_n = 1'b1;
      #(2.0 * BIT0);

      // table-driven clean frames, including +/-3% baud skew
      for (int i = 0; i < 5; i++) begin
         bns = 1.0e9 / (115200.0 * (1.0 + real'(tbl[i].skew_pct) / 100.0));
         ferr_cnt = 0;
         exp_q.push_back(tbl[i].exp_dat);
         send_frame(tbl[i].data, 1'b1, bns);
         @(negedge clk);
         check($sformatf("vec%0d_busy", i), {31'd0, busy}, 32'd0);
         get_byte($sformatf("vec%0d", i));
         check($sformatf("vec%0d_ferr", i), ferr_cnt, 32'd0);
         #(BIT0);
      end

      // false start: short low pulse
      ferr_cnt = 0;
      @(negedge clk) rx = 1'b0;
      repeat (20) @(negedge clk);
      rx = 1'b1;
      #(BIT0);
      @(negedge clk);
      check("fs_busy",  {31'd0, busy},  32'd0);
      check("fs_valid", {31'd0, valid}, 32'd0);
      check("fs_ferr",  ferr_cnt,       32'd0);
      #(BIT0);

      // framing error with line held low, then a clean frame
      ferr_cnt = 0;
      send_frame(8'hA3, 1'b0, BIT0);
      #(2.0 * BIT0);
      @(negedge clk);
      check("fe_pulse", ferr_cnt,       32'd1);
      check("fe_valid", {31'd0, valid}, 32'd0);
      check("fe_busy",  {31'd0, busy},  32'd1);
      rx = 1'b1;
      repeat (5) @(negedge clk);
      check("fe_idle",  {31'd0, busy},  32'd0);
      #(BIT0);
      exp_q.push_back(8'h3C);
      send_frame(8'h3C, 1'b1, BIT0);
      get_byte("fe_next");

      // overrun: back-to-back frames, no ack
      #(BIT0);
      exp_q.push_back(8'h12);
      send_frame(8'h12, 1'b1, BIT0);
      exp_q.push_back(8'h34);
      send_frame(8'h34, 1'b1, BIT0);
      wait_valid("ovr");
      pop_cmp("ovr");
      check("ovr_set", {31'd0, ovr}, 32'd1);
      ack_pulse();
      check("ovr_ack_valid", {31'd0, valid}, 32'd0);
      check("ovr_ack_ovr",   {31'd0, ovr},   32'd0);

      // ack in the same cycle as a new delivery
      #(BIT0);
      exp_q.push_back(8'h56);
      send_frame(8'h56, 1'b1, BIT0);
      wait_valid("sc_first");
      fork
         begin
            exp_q.push_back(8'h78);
            send_frame(8'h78, 1'b1, BIT0);
         end
         begin
            int k = 0;
            @(negedge clk);
            while (dut.w_deliver !== 1'b1 && k < 5000) begin
               @(negedge clk);
               k++;
            end
            check("sc_found", {31'd0, dut.w_deliver}, 32'd1);
            ack = 1'b1;
            @(negedge clk) ack = 1'b0;
            check("sc_valid", {31'd0, valid}, 32'd1);
            check("sc_ovr",   {31'd0, ovr},   32'd0);
         end
      join
      pop_cmp("sc");
      ack_pulse();

      // reset mid-frame with a pending byte
      #(BIT0);
      exp_q.push_back(8'h77);
      send_frame(8'h77, 1'b1, BIT0);
      wait_valid("pre_rst");
      pop_cmp("pre_rst");
      rx = 1'b0;
      #(BIT0);
      rx = 1'b1;
      #(2.0 * BIT0);
      @(negedge clk);
      check("mid_busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #10;
      check("mr_dat",   {24'd0, dat},   32'd0);
      check("mr_valid", {31'd0, valid}, 32'd0);
      check("mr_ovr",   {31'd0, ovr},   32'd0);
      check("mr_busy",  {31'd0, busy},  32'd0);
      #(7.0 * BIT0);
      @(negedge clk) rst_n = 1'b1;
      #(BIT0);
      exp_q.push_back(8'hC3);
      send_frame(8'hC3, 1'b1, BIT0);
      get_byte("post_rst");

`ifdef UART_RX_MAJORITY_EN
      // one-tick high glitch around os_cnt 7 of data bit 2 (a 0)
      #(BIT0);
      exp_q.push_back(8'h00);
      rx = 1'b0;
      #(BIT0);
      for (int i = 0; i < 8; i++) begin
         real t0;
         t0 = $realtime;
         rx = 1'b0;
         if (i == 2) begin
            int k = 0;
            @(negedge clk);
            while (!(dut.w_tick === 1'b1 && dut.r_os_cnt == 4'd6) && k < 200) begin
               @(negedge clk);
               k++;
            end
            check("gl_found", {31'd0, dut.w_tick}, 32'd1);
            @(posedge clk);
            #1 rx = 1'b1;
            repeat (5) @(posedge clk);
            #1 rx = 1'b0;
         end
         #(t0 + BIT0 - $realtime);
      end
      rx = 1'b1;
      #(BIT0);
      get_byte("glitch");
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver that consumes the 8N1 line produced by the team's UART transmitter and delivers parallel bytes to the core.
- Oversamples the line at 16x baud using a fractional phase-accumulator tick generator. Checks the start and stop bits.
- Presents each byte on a valid/ack handshake and flags framing errors and overruns.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bits/s.
- OVS, 16, oversample ratio; fixed at 16 (constant in package, not overridable).

Ports:
- sys_clk_i  input  1  system clock.
- sys_rstn_i  input  1  reset. Asynchronous assert, active-low.
- uart_rx_i  input  1  serial line. Asynchronous to clock; idle high.
- uart_ack_i  input  1  consumer accepts the byte on uart_dat_o this cycle.
- uart_dat_o  output  8  received byte. Held until replaced.
- uart_valid_o  output  1  byte available. Level; held until ack.
- uart_ferr_o  output  1  framing error. 1-cycle pulse.
- uart_ovr_o  output  1  overrun. Sticky; cleared by ack.
- uart_busy_o  output  1  frame in progress (state != IDLE).

Behaviour:
- Reset (sys_rstn_i low, asynchronous, any time including mid-frame):
  - Both synchronizer flops = 1.
  - Accumulator = 0, state = IDLE, os_cnt = 0, bit_idx = 0, shift = 0.
  - uart_dat_o = 0x00; uart_valid_o, uart_ferr_o, uart_ovr_o, uart_busy_o = 0.
- Synchronizer: 2-flop on uart_rx_i; rx_s = second stage. Every decision below uses rx_s only.
- Tick generator:
  - 32-bit accumulator; INC = OVS*BAUD.
  - Each cycle: if acc+INC >= CLK_HZ then acc <= acc+INC-CLK_HZ and tick = 1; else acc <= acc+INC and tick = 0.
  - Free-running; never reset by the FSM.
- os_cnt: 4-bit, advances only on tick, wraps 15->0. Cleared to 0 on the IDLE->START transition.
- FSM states: IDLE, START, DATA, STOP, RECOVER.
  - IDLE: rx_s==0 -> START.
  - START, at tick with os_cnt==8: sampled bit 1 -> IDLE (false start, no flags). At tick with os_cnt==15 -> DATA, bit_idx = 0.
  - DATA: sampled bit captured at tick with os_cnt==8. At tick with os_cnt==15 the captured bit shifts into shift[7] (shift right, LSB first) and bit_idx increments. After bit_idx 7 -> STOP.
  - STOP, at tick with os_cnt==8 (no wait for full stop bit, so back-to-back frames work):
    - Sample 1 -> uart_dat_o <= shift, uart_valid_o <= 1, -> IDLE.
    - Sample 0 -> uart_ferr_o pulses 1 cycle, no valid, -> RECOVER.
  - RECOVER: rx_s==1 -> IDLE. Prevents a break condition from retriggering.
- Sample value: rx_s at os_cnt==7 (default build).
- Latency: uart_valid_o rises the cycle after the STOP os_cnt==8 tick.
- Handshake:
  - uart_ack_i while valid==1 -> valid <= 0 and ovr <= 0 next cycle.
  - ack while valid==0 is ignored.
- New byte delivered while valid==1 and no ack in the same cycle: dat overwritten, valid stays 1, ovr <= 1.
- New byte delivered in the same cycle as ack: new byte wins, valid stays 1, ovr <= 0.
- uart_busy_o is combinational from state.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: sample value = 2-of-3 majority of rx_s at os_cnt 6, 7, 8; the decision point stays at os_cnt==8. Applies to START, DATA and STOP. A 1-tick glitch near bit centre is rejected.
- Undefined: single sample at os_cnt==7. No extra flops.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE, START, DATA, STOP, RECOVER).
  - OVS = 16.
  - SAMPLE_POS = 7, DECIDE_POS = 8, LAST_POS = 15.
  - Accumulator width constant 32.
- Sub-module uart_baud_tick:
  - Parameters CLK_HZ, BAUD, MULT.
  - Ports sys_clk_i, sys_rstn_i, tick_o.
  - Reusable later for a TX FIFO pacer.

Test Plan:
- Reset, idle line, then frame 0x55 at 115200 (868 clk/bit) -> one byte: uart_valid_o=1, uart_dat_o=0x55, ferr=0, ovr=0; busy returns 0 after stop-bit centre.
- Line low for 200 cycles, then high -> START rejects the false start; no valid, no ferr; state IDLE within 1 bit time.
- Frame 0xA3 with stop bit 0, line held low 3 bit times -> ferr pulses exactly 1 cycle; valid stays 0; busy stays 1 until line high; following frame 0x3C received correctly.
- Frames 0x12 then 0x34 back-to-back, no ack -> dat=0x34, valid=1, ovr=1; then ack -> valid=0, ovr=0 next cycle. Also ack in the same cycle as delivery of 0x34 -> valid=1, ovr=0.
- Reset asserted mid-DATA of 0xFF, released -> all outputs 0 immediately; next frame 0xC3 received correctly.
- Frames 0xF0 sent at BAUD +3% and -3% -> both received as 0xF0. With UART_RX_MAJORITY_EN: 1-tick high glitch at os_cnt 7 of a 0 data bit -> byte unaffected.
